// File: rtl/muldiv_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] DIV0_QUOT  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] SIGNED_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [2:0] {
        OP_MUL    = 3'b000,
        OP_MULH   = 3'b001,
        OP_MULHSU = 3'b010,
        OP_MULHU  = 3'b011,
        OP_DIV    = 3'b100,
        OP_DIVU   = 3'b101,
        OP_REM    = 3'b110,
        OP_REMU   = 3'b111
    } muldiv_op_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/muldiv_operand_fmt.sv
// Combinational operand extension to the unit width plus detection of the
// divide cases whose result is fixed by the ISA (divide by zero, signed overflow).
module muldiv_operand_fmt #(
    parameter int XLEN = 32
) (
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN:0]   opa,
    output logic [XLEN:0]   opb,
    output logic            is_div,
    output logic            special,
    output logic [XLEN-1:0] special_res
);
    import muldiv_pkg::*;

    muldiv_op_e fop;
    logic       sign_a;
    logic       sign_b;

    // op[1] separates REM/REMU from DIV/DIVU within the divide group
    always_comb begin
        fop    = muldiv_op_e'(op);
        sign_a = fop inside {OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
        sign_b = fop inside {OP_MUL, OP_MULH, OP_DIV, OP_REM};
        opa    = {sign_a & a[XLEN-1], a};
        opb    = {sign_b & b[XLEN-1], b};
        is_div = op[2];
        special     = 1'b0;
        special_res = '0;
        if (is_div && (b == '0)) begin
            special     = 1'b1;
            special_res = op[1] ? a : DIV0_QUOT;
        end else if ((fop == OP_DIV || fop == OP_REM) && (a == SIGNED_MIN) && (b == '1)) begin
            special     = 1'b1;
            special_res = (fop == OP_DIV) ? SIGNED_MIN : '0;
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencer between EX and the shared 33-bit iterative multiplier/divider.
// Optional result reuse cache enabled by defining MULDIV_REUSE_EN.
module muldiv_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            Clk,
    input  logic            Reset,
    input  logic            req_valid,
    input  logic [2:0]      req_op,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            req_ready,
    input  logic            flush,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_data,
    output logic            mul_run,
    output logic            mul_div,
    output logic [XLEN:0]   mul_opA,
    output logic [XLEN:0]   mul_opB,
    input  logic            mul_ready,
    input  logic [XLEN:0]   mul_Aval,
    input  logic [XLEN:0]   mul_Bval
);
    import muldiv_pkg::*;

    ctrl_state_e       state, state_n;
    logic              kill, kill_n;
    logic [2:0]        op_q;
    logic              resp_valid_n;
    logic [XLEN-1:0]   resp_data_n;
    logic              accept;
    logic              capture;
    logic              capture_ok;
    logic [XLEN:0]     fmt_opa, fmt_opb;
    logic              fmt_div, fmt_special;
    logic [XLEN-1:0]   fmt_special_res;
    logic [2*XLEN+1:0] live_p;
    logic              cache_hit;
    logic [2*XLEN+1:0] cache_p_out;
    logic              unused_aval_msb;

    // P is {Aval, Bval}; the quotient and MUL low word share P[XLEN-1:0]
    function automatic logic [XLEN-1:0] sel_result(input logic [2:0] op, input logic [2*XLEN+1:0] p);
        case (muldiv_op_e'(op))
            OP_MUL, OP_DIV, OP_DIVU:      return p[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU: return p[2*XLEN-1:XLEN];
            default:                      return p[2*XLEN:XLEN+1];
        endcase
    endfunction

    muldiv_operand_fmt #(.XLEN(XLEN)) u_fmt (
        .op          (req_op),
        .a           (req_a),
        .b           (req_b),
        .opa         (fmt_opa),
        .opb         (fmt_opb),
        .is_div      (fmt_div),
        .special     (fmt_special),
        .special_res (fmt_special_res)
    );

    assign live_p          = {mul_Aval, mul_Bval};
    assign req_ready       = (state == IDLE);
    assign mul_run         = (state == BUSY);
    assign capture_ok      = capture && !(kill || flush);
    assign unused_aval_msb = mul_Aval[XLEN];

`ifdef MULDIV_REUSE_EN
    logic              cache_valid;
    logic [2*XLEN+1:0] cache_p;
    logic [XLEN:0]     cache_a, cache_b;
    logic              cache_div;

    assign cache_hit   = cache_valid && (cache_a == fmt_opa) && (cache_b == fmt_opb) && (cache_div == fmt_div);
    assign cache_p_out = cache_p;

    // The entry is only trusted when the operation that produced it was not killed
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            cache_valid <= 1'b0;
            cache_p     <= '0;
            cache_a     <= '0;
            cache_b     <= '0;
            cache_div   <= 1'b0;
        end else if (capture_ok) begin
            cache_valid <= 1'b1;
            cache_p     <= live_p;
            cache_a     <= mul_opA;
            cache_b     <= mul_opB;
            cache_div   <= mul_div;
        end else if (flush || (capture && kill)) begin
            cache_valid <= 1'b0;
        end
    end
`else
    assign cache_hit   = 1'b0;
    assign cache_p_out = '0;
`endif

    always_comb begin
        state_n      = state;
        kill_n       = kill;
        resp_valid_n = 1'b0;
        resp_data_n  = resp_data;
        accept       = 1'b0;
        capture      = 1'b0;
        case (state)
            IDLE: begin
                if (!flush && req_valid) begin
                    if (fmt_special) begin
                        resp_valid_n = 1'b1;
                        resp_data_n  = fmt_special_res;
                    end else if (cache_hit) begin
                        resp_valid_n = 1'b1;
                        resp_data_n  = sel_result(req_op, cache_p_out);
                    end else begin
                        accept  = 1'b1;
                        state_n = BUSY;
                    end
                end
            end
            BUSY: begin
                if (flush)
                    kill_n = 1'b1;
                if (mul_ready) begin
                    capture = 1'b1;
                    state_n = RELEASE;
                    if (!(kill || flush)) begin
                        resp_valid_n = 1'b1;
                        resp_data_n  = sel_result(op_q, live_p);
                    end
                end
            end
            RELEASE: begin
                // Run may only rise again once the unit has dropped ready
                if (!mul_ready) begin
                    state_n = IDLE;
                    kill_n  = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
                kill_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state      <= IDLE;
            kill       <= 1'b0;
            op_q       <= '0;
            mul_div    <= 1'b0;
            mul_opA    <= '0;
            mul_opB    <= '0;
            resp_valid <= 1'b0;
            resp_data  <= '0;
        end else begin
            state      <= state_n;
            kill       <= kill_n;
            resp_valid <= resp_valid_n;
            resp_data  <= resp_data_n;
            if (accept) begin
                op_q    <= req_op;
                mul_div <= fmt_div;
                mul_opA <= fmt_opa;
                mul_opB <= fmt_opb;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl; the bench plays the multiplier unit itself.
// Honours MULDIV_REUSE_EN for the DIV->REM reuse case.
module tb_muldiv_ctrl;

    localparam int XLEN = 32;

    logic            Clk = 1'b0;
    logic            Reset;
    logic            req_valid;
    logic [2:0]      req_op;
    logic [XLEN-1:0] req_a, req_b;
    logic            req_ready;
    logic            flush;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    logic            mul_run, mul_div;
    logic [XLEN:0]   mul_opA, mul_opB;
    logic            mul_ready;
    logic [XLEN:0]   mul_Aval, mul_Bval;

    int compared   = 0;
    int mismatched = 0;

    muldiv_ctrl #(.XLEN(XLEN)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .req_valid  (req_valid),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .mul_run    (mul_run),
        .mul_div    (mul_div),
        .mul_opA    (mul_opA),
        .mul_opB    (mul_opB),
        .mul_ready  (mul_ready),
        .mul_Aval   (mul_Aval),
        .mul_Bval   (mul_Bval)
    );

    always #5 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    // Presents a request for one clock, driven and released on falling edges
    task automatic applyStimulus(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        @(negedge Clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        @(negedge Clk);
        req_valid = 1'b0;
    endtask

    // Full unit round trip; p is the 66-bit product/quotient-remainder pair the unit reports
    task automatic runUnitOp(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b, input logic [XLEN:0] expA, input logic [XLEN:0] expB,
                             input logic expDiv, input logic [65:0] p, input logic [XLEN-1:0] expData);
        checkOutput({tag, ".ready_idle"}, 64'(req_ready), 64'd1);
        applyStimulus(op, a, b);
        checkOutput({tag, ".run"}, 64'(mul_run), 64'd1);
        checkOutput({tag, ".ready_busy"}, 64'(req_ready), 64'd0);
        checkOutput({tag, ".opA"}, 64'(mul_opA), 64'(expA));
        checkOutput({tag, ".opB"}, 64'(mul_opB), 64'(expB));
        checkOutput({tag, ".div"}, 64'(mul_div), 64'(expDiv));
        @(negedge Clk);
        checkOutput({tag, ".no_early_resp"}, 64'(resp_valid), 64'd0);
        mul_Aval  = p[65:33];
        mul_Bval  = p[32:0];
        mul_ready = 1'b1;
        @(negedge Clk);
        checkOutput({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
        checkOutput({tag, ".resp_data"}, 64'(resp_data), 64'(expData));
        checkOutput({tag, ".run_release"}, 64'(mul_run), 64'd0);
        checkOutput({tag, ".opA_held"}, 64'(mul_opA), 64'(expA));
        @(negedge Clk);
        checkOutput({tag, ".pulse_end"}, 64'(resp_valid), 64'd0);
        checkOutput({tag, ".ready_release"}, 64'(req_ready), 64'd0);
        checkOutput({tag, ".data_hold"}, 64'(resp_data), 64'(expData));
        mul_ready = 1'b0;
        @(negedge Clk);
        checkOutput({tag, ".ready_back"}, 64'(req_ready), 64'd1);
    endtask

    // Special-case or cached answer: response right after accept, unit untouched
    task automatic runBypass(input string tag, input logic [2:0] op, input logic [XLEN-1:0] a,
                             input logic [XLEN-1:0] b, input logic [XLEN-1:0] expData);
        applyStimulus(op, a, b);
        checkOutput({tag, ".resp_valid"}, 64'(resp_valid), 64'd1);
        checkOutput({tag, ".resp_data"}, 64'(resp_data), 64'(expData));
        checkOutput({tag, ".no_run"}, 64'(mul_run), 64'd0);
        checkOutput({tag, ".ready"}, 64'(req_ready), 64'd1);
        @(negedge Clk);
        checkOutput({tag, ".pulse_end"}, 64'(resp_valid), 64'd0);
        checkOutput({tag, ".no_run_after"}, 64'(mul_run), 64'd0);
    endtask

    initial begin
        logic [65:0] p;
        logic        saw_resp;
        Reset = 1'b1; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        flush = 1'b0; mul_ready = 1'b0; mul_Aval = '0; mul_Bval = '0;

        @(negedge Clk);
        checkOutput("rst.ready", 64'(req_ready), 64'd1);
        checkOutput("rst.resp_valid", 64'(resp_valid), 64'd0);
        checkOutput("rst.resp_data", 64'(resp_data), 64'd0);
        checkOutput("rst.run", 64'(mul_run), 64'd0);
        checkOutput("rst.div", 64'(mul_div), 64'd0);
        checkOutput("rst.opA", 64'(mul_opA), 64'd0);
        checkOutput("rst.opB", 64'(mul_opB), 64'd0);
        Reset = 1'b0;

        runUnitOp("mul7x2", 3'b000, 32'd7, 32'd2, 33'd7, 33'd2, 1'b0, 66'd14, 32'd14);

        // DIV 7/2: remainder 1 in Aval, quotient 3 in Bval
        p = {33'd1, 33'd3};
        runUnitOp("div7_2", 3'b100, 32'd7, 32'd2, 33'd7, 33'd2, 1'b1, p, 32'd3);
`ifdef MULDIV_REUSE_EN
        runBypass("rem7_2_reuse", 3'b110, 32'd7, 32'd2, 32'd1);
`else
        runUnitOp("rem7_2", 3'b110, 32'd7, 32'd2, 33'd7, 33'd2, 1'b1, p, 32'd1);
`endif

        p = 66'h0_FFFF_FFFE_0000_0001;
        runUnitOp("mulhu_max", 3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h0_FFFF_FFFF, 33'h0_FFFF_FFFF, 1'b0, p, 32'hFFFF_FFFE);
        runUnitOp("mulh_m1", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b0, 66'd1, 32'h0);
        // MULHSU -1 * 0xFFFFFFFF = -0xFFFFFFFF: high word is all ones
        p = 66'h3_FFFF_FFFF_0000_0001;
        runUnitOp("mulhsu", 3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33'h1_FFFF_FFFF, 33'h0_FFFF_FFFF, 1'b0, p, 32'hFFFF_FFFF);

        runBypass("divu_by0", 3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
        runBypass("remu_by0", 3'b111, 32'd5, 32'd0, 32'd5);
        runBypass("div_ovf", 3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        runBypass("rem_ovf", 3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

        // Flush two cycles into BUSY: result must be discarded
        saw_resp = 1'b0;
        applyStimulus(3'b000, 32'd9, 32'd9);
        checkOutput("flush.run", 64'(mul_run), 64'd1);
        @(negedge Clk);
        flush = 1'b1;
        @(negedge Clk);
        flush = 1'b0;
        saw_resp |= resp_valid;
        mul_Aval = '0; mul_Bval = 33'd81; mul_ready = 1'b1;
        @(negedge Clk);
        saw_resp |= resp_valid;
        checkOutput("flush.run_drop", 64'(mul_run), 64'd0);
        checkOutput("flush.ready_release", 64'(req_ready), 64'd0);
        @(negedge Clk);
        saw_resp |= resp_valid;
        mul_ready = 1'b0;
        @(negedge Clk);
        saw_resp |= resp_valid;
        checkOutput("flush.no_resp", 64'(saw_resp), 64'd0);
        checkOutput("flush.ready_back", 64'(req_ready), 64'd1);
        checkOutput("flush.data_kept", 64'(resp_data), 64'h0);

        // Flush beats a presented request, even one that would bypass
        flush = 1'b1;
        applyStimulus(3'b101, 32'd5, 32'd0);
        flush = 1'b0;
        checkOutput("idleflush.resp", 64'(resp_valid), 64'd0);
        checkOutput("idleflush.run", 64'(mul_run), 64'd0);
        checkOutput("idleflush.ready", 64'(req_ready), 64'd1);
        flush = 1'b1;
        applyStimulus(3'b000, 32'd3, 32'd3);
        flush = 1'b0;
        checkOutput("idleflush2.run", 64'(mul_run), 64'd0);

        // Asynchronous reset in the middle of BUSY
        applyStimulus(3'b001, 32'h1234_5678, 32'h9ABC_DEF0);
        checkOutput("midrst.run_before", 64'(mul_run), 64'd1);
        #2 Reset = 1'b1;
        #1;
        checkOutput("midrst.ready", 64'(req_ready), 64'd1);
        checkOutput("midrst.run", 64'(mul_run), 64'd0);
        checkOutput("midrst.opA", 64'(mul_opA), 64'd0);
        checkOutput("midrst.opB", 64'(mul_opB), 64'd0);
        checkOutput("midrst.data", 64'(resp_data), 64'd0);
        @(negedge Clk);
        Reset = 1'b0;
        runUnitOp("mul3x4", 3'b000, 32'd3, 32'd4, 33'd3, 33'd4, 1'b0, 66'd12, 32'd12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Absolute time limit so a broken DUT cannot stall the run
    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running, expected finished");
        mismatched++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "[TB] timeout");
    end

endmodule
